multicycle_controller: RTL and testbench

Multi-cycle control unit for the 32-bit load/store/R-type/I-type datapath. It replaces the fixed, bench-driven control lines with a five-state sequencer: fetch, decode, execute, memory, write-back. It decodes the opcode and funct fields of the fetched instruction and drives RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst and ALU_OP into the datapath. It also drives PC/IR enables and waits on a data-memory ready handshake.

---
 rtl/multicycle_controller.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Five-state multi-cycle control unit: fetch, decode, execute, memory, write-back.
// Drives datapath controls as Moore outputs from the state and the opcode/funct latched in DECODE.
module multicycle_controller #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instruction_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             alu_src_o,
    output logic             reg_dst_o,
    output logic [3:0]       alu_op_o,
    output logic [2:0]       state_o,
    output logic             illegal_o,
    output logic             bus_error_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    // Packed decode result: {legal, is_lw, is_sw, is_rtype, alu_op[3:0]}
    function automatic logic [7:0] decode(input logic [5:0] op, input logic [5:0] fn);
        logic       legal;
        logic       is_lw;
        logic       is_sw;
        logic       is_r;
        logic [3:0] alu;
        legal = 1'b1;
        is_lw = 1'b0;
        is_sw = 1'b0;
        is_r  = 1'b0;
        alu   = ALU_ADD;
        case (op)
            OP_LW:   is_lw = 1'b1;
            OP_SW:   is_sw = 1'b1;
            OP_ADDI: alu = ALU_ADD;
            OP_ANDI: alu = ALU_AND;
            OP_ORI:  alu = ALU_OR;
            OP_RTYPE: begin
                is_r = 1'b1;
                case (fn)
                    6'b100000: alu = ALU_ADD;
                    6'b100010: alu = ALU_SUB;
                    6'b100100: alu = ALU_AND;
                    6'b100101: alu = ALU_OR;
                    6'b101010: alu = ALU_SLT;
                    default:   legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        return {legal, is_lw, is_sw, is_r, alu};
    endfunction

    logic [2:0]       state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [5:0]       funct_q, funct_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             bus_error_q, bus_error_d;

    logic [7:0] dec_in;
    logic [7:0] dec_lat;
    logic       in_legal;
    logic       lat_lw;
    logic       lat_sw;
    logic       lat_r;
    logic [3:0] lat_alu;

    assign dec_in   = decode(instruction_i[31:26], instruction_i[5:0]);
    assign dec_lat  = decode(opcode_q, funct_q);
    assign in_legal = dec_in[7];
    assign lat_lw   = dec_lat[6];
    assign lat_sw   = dec_lat[5];
    assign lat_r    = dec_lat[4];
    assign lat_alu  = dec_lat[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            opcode_q    <= '0;
            funct_q     <= '0;
            wait_q      <= '0;
            retired_q   <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            funct_q     <= funct_d;
            wait_q      <= wait_d;
            retired_q   <= retired_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Event pulses are registered, so they appear in the cycle after the decision (the next FETCH).
    always_comb begin
        state_d     = S_FETCH;
        opcode_d    = opcode_q;
        funct_d     = funct_q;
        retired_d   = retired_q;
        illegal_d   = 1'b0;
        bus_error_d = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = instruction_i[31:26];
                funct_d  = instruction_i[5:0];
                if (in_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: state_d = (lat_lw || lat_sw) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready_i) begin
                    if (lat_lw) begin
                        state_d = S_WB;
                    end else begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_error_d = 1'b1;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: retired_d = retired_q + CNT_W'(1);
            default: state_d = S_FETCH;
        endcase
    end

    // Counter runs only while staying in MEM, so every entry starts from zero.
    always_comb begin
        wait_d = '0;
        if (state_q == S_MEM && state_d == S_MEM) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_o    = 1'b0;
        reg_dst_o    = 1'b0;
        alu_op_o     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                // Held off while reset is asserted so reset shows every control low.
                pc_write_o = rst_n;
                ir_write_o = rst_n;
            end
            S_EXEC: begin
                alu_op_o  = lat_alu;
                alu_src_o = !lat_r;
            end
            S_MEM: begin
                alu_op_o    = lat_alu;
                alu_src_o   = !lat_r;
                mem_read_o  = lat_lw;
                mem_write_o = lat_sw;
            end
            S_WB: begin
                alu_op_o     = lat_alu;
                alu_src_o    = !lat_r;
                reg_write_o  = 1'b1;
                mem_to_reg_o = lat_lw;
                reg_dst_o    = lat_r;
            end
            default: ;
        endcase
    end

    assign state_o     = state_q;
    assign illegal_o   = illegal_q;
    assign bus_error_o = bus_error_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle expected outputs are queued when an instruction is issued
// and popped/compared every cycle as the controller sequences through it.
module tb_multicycle_controller;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;

    logic             clk;
    logic             rst_n;
    logic [31:0]      instruction;
    logic             mem_ready;
    logic             pc_write, ir_write, reg_write, mem_read, mem_write;
    logic             mem_to_reg, alu_src, reg_dst;
    logic [3:0]       alu_op;
    logic [2:0]       state;
    logic             illegal, bus_error;
    logic [CNT_W-1:0] retired;

    multicycle_controller #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instruction_i(instruction),
        .mem_ready_i  (mem_ready),
        .pc_write_o   (pc_write),
        .ir_write_o   (ir_write),
        .reg_write_o  (reg_write),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_to_reg_o (mem_to_reg),
        .alu_src_o    (alu_src),
        .reg_dst_o    (reg_dst),
        .alu_op_o     (alu_op),
        .state_o      (state),
        .illegal_o    (illegal),
        .bus_error_o  (bus_error),
        .retired_o    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        mr;
        logic [20:0] exp;
    } cyc_t;

    cyc_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc_no = 0;
    string      cur_test = "none";
    logic       pend_ill = 1'b0;
    logic       pend_berr = 1'b0;
    logic [3:0] exp_ret = 4'd0;

    function automatic logic [20:0] observed();
        return {state, pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
                alu_src, reg_dst, alu_op, illegal, bus_error, retired};
    endfunction

    function automatic logic [20:0] mk(input logic [2:0] st, input logic pcw, input logic irw,
                                       input logic rw, input logic mrd, input logic mwr,
                                       input logic m2r, input logic asrc, input logic rdst,
                                       input logic [3:0] alu, input logic ill, input logic berr,
                                       input logic [3:0] ret);
        return {st, pcw, irw, rw, mrd, mwr, m2r, asrc, rdst, alu, ill, berr, ret};
    endfunction

    // Reference classification straight from the instruction table: cls 0=lw 1=sw 2=R 3=I
    task automatic classify(input logic [31:0] ins, output bit legal, output int cls,
                            output logic [3:0] alu);
        legal = 1'b1;
        cls   = 3;
        alu   = 4'b0010;
        case (ins[31:26])
            6'b100011: cls = 0;
            6'b101011: cls = 1;
            6'b001000: alu = 4'b0010;
            6'b001100: alu = 4'b0000;
            6'b001101: alu = 4'b0001;
            6'b000000: begin
                cls = 2;
                case (ins[5:0])
                    6'b100000: alu = 4'b0010;
                    6'b100010: alu = 4'b0110;
                    6'b100100: alu = 4'b0000;
                    6'b100101: alu = 4'b0001;
                    6'b101010: alu = 4'b0111;
                    default:   legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    endtask

    task automatic push_fetch();
        cyc_t c;
        c.instr = $urandom;
        c.mr    = 1'($urandom);
        c.exp   = mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0010, pend_ill, pend_berr, exp_ret);
        sb.push_back(c);
        pend_ill  = 1'b0;
        pend_berr = 1'b0;
    endtask

    // low = MEM cycles with mem_ready low before it rises; >= WAIT_MAX means it never does.
    task automatic push_instr(input logic [31:0] ins, input int low);
        bit         legal;
        int         cls;
        logic [3:0] alu;
        logic       asrc;
        cyc_t       c;
        classify(ins, legal, cls, alu);
        asrc = (cls != 2);
        push_fetch();
        c.instr = ins;
        c.mr    = 1'($urandom);
        c.exp   = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, exp_ret);
        sb.push_back(c);
        if (!legal) begin
            pend_ill = 1'b1;
            return;
        end
        c.instr = $urandom;
        c.mr    = 1'($urandom);
        c.exp   = mk(3'd2, 0, 0, 0, 0, 0, 0, asrc, 0, alu, 0, 0, exp_ret);
        sb.push_back(c);
        if (cls <= 1) begin
            for (int k = 0; k < WAIT_MAX; k++) begin
                c.instr = $urandom;
                c.mr    = (k >= low);
                c.exp   = mk(3'd3, 0, 0, 0, cls == 0, cls == 1, 0, asrc, 0, alu, 0, 0, exp_ret);
                sb.push_back(c);
                if (c.mr) begin
                    if (cls == 1) begin
                        exp_ret = exp_ret + 4'd1;
                        return;
                    end
                    break;
                end else if (k == WAIT_MAX - 1) begin
                    pend_berr = 1'b1;
                    return;
                end
            end
        end
        c.instr = $urandom;
        c.mr    = 1'($urandom);
        c.exp   = mk(3'd4, 0, 0, 1, 0, 0, cls == 0, asrc, cls == 2, alu, 0, 0, exp_ret);
        sb.push_back(c);
        exp_ret = exp_ret + 4'd1;
    endtask

    // Called at a falling edge; consumes up to n queued cycles (n < 0: all).
    task automatic run_queue(input int n);
        cyc_t        c;
        logic [20:0] got;
        int          done = 0;
        while (sb.size() > 0 && (n < 0 || done < n)) begin
            c = sb.pop_front();
            instruction = c.instr;
            mem_ready   = c.mr;
            #1;
            got = observed();
            checks++;
            if (got !== c.exp) begin
                errors++;
                $display("FAIL %s cyc%0d: outputs got %h expected %h", cur_test, cyc_no, got, c.exp);
            end
            cyc_no++;
            done++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [20:0] want;
        want = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 4'd0);
        checks++;
        if (observed() !== want) begin
            errors++;
            $display("FAIL %s: outputs got %h expected %h", tag, observed(), want);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        instruction = 32'h8C410001;
        mem_ready   = 1'b1;
        #2;
        check_reset_outputs("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        $display("reset released, retired=%0d", retired);
    endtask

    task automatic test_lw();
        cur_test = "lw";
        push_instr(32'h8C410001, 0);
        run_queue(-1);
        $display("lw 8C410001 done, retired=%0d", retired);
    endtask

    task automatic test_sw_wait();
        cur_test = "sw_wait3";
        push_instr(32'hACA50002, 3);
        run_queue(-1);
        $display("sw ACA50002 with 3 wait cycles done, retired=%0d", retired);
    endtask

    task automatic test_rtype_itype();
        logic [31:0] sweep [7];
        sweep = '{32'h0128A822, 32'h30D60000, 32'h20420005, 32'h34630F0F,
                  32'h01084020, 32'h014B6024, 32'h018D702A};
        cur_test = "ri_sweep";
        for (int i = 0; i < 7; i++) begin
            push_instr(sweep[i], 0);
            run_queue(-1);
            $display("R/I instr %h done, retired=%0d", sweep[i], retired);
        end
        push_instr(32'h01AE7825, 0);
        run_queue(-1);
        $display("or 01AE7825 done, retired=%0d", retired);
    endtask

    task automatic test_illegal();
        cur_test = "illegal";
        push_instr(32'hFC000000, 0);
        push_instr(32'h0000003F, 0);
        push_instr(32'h20010001, 0);
        run_queue(-1);
        $display("illegal opcode and funct sequence done, retired=%0d", retired);
    endtask

    task automatic test_timeout();
        cur_test = "timeout";
        push_instr(32'h8C410001, 100);
        push_instr(32'hACA50002, 100);
        run_queue(-1);
        $display("lw/sw timeout sequence done, retired=%0d", retired);
        cur_test = "ready_at_limit";
        push_instr(32'h8C410001, WAIT_MAX - 1);
        push_instr(32'hACA50002, WAIT_MAX - 1);
        run_queue(-1);
        $display("ready on last wait cycle done, retired=%0d", retired);
    endtask

    task automatic test_back_to_back();
        logic [31:0] base [10];
        logic [31:0] ins;
        int          low;
        base = '{32'h8C000000, 32'hAC000000, 32'h20000000, 32'h30000000, 32'h34000000,
                 32'h00000020, 32'h00000022, 32'h00000024, 32'h00000025, 32'h0000002A};
        cur_test = "back_to_back";
        for (int i = 0; i < 40; i++) begin
            ins = base[$urandom_range(0, 9)];
            if (ins[31:26] == 6'b000000) ins[25:6] = 20'($urandom);
            else ins[25:0] = 26'($urandom);
            if ($urandom_range(0, 9) == 0) ins = 32'hFC000000 | 32'($urandom_range(0, 255));
            low = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            push_instr(ins, low);
            run_queue(-1);
            $display("b2b instr %h low=%0d done, retired=%0d", ins, low, retired);
        end
    endtask

    task automatic test_reset_mid_lw();
        cur_test = "reset_mid_lw";
        push_instr(32'h8C410001, 100);
        run_queue(5);
        sb.delete();
        #1;
        checks++;
        if (mem_read !== 1'b1 || state !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_mem: mem_read got %b state %0d expected 1 and 3", mem_read, state);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_lw");
        pend_ill  = 1'b0;
        pend_berr = 1'b0;
        exp_ret   = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        push_instr(32'h0128A822, 0);
        push_fetch();
        run_queue(-1);
        $display("reset mid-lw recovery done, retired=%0d", retired);
    endtask

    initial begin
        rst_n       = 1'b0;
        instruction = '0;
        mem_ready   = 1'b0;
        #12;
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype_itype();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid_lw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
